// File: rtl/scan_row_sampler_pkg.sv
// Shared pixel-domain types: coordinates, RGB triplets and the segment averaging helper.
package scan_pkg;

  localparam int COORD_W = 12;
  localparam int SUM_W   = 20;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // Truncating average of a power-of-two sample count.
  function automatic logic [7:0] rgb_avg(input logic [SUM_W-1:0] sum, input int shift);
    return 8'(sum >> shift);
  endfunction

endpackage

// File: rtl/scan_row_sampler_if.sv
// Video stream in/out plus the per-segment result strobes of the scan-row sampler.
interface scan_row_sampler_if #(
  parameter int IDX_W = 5
);

  logic [23:0]      data_i;
  logic             vde_i;
  logic             hsync_i;
  logic             vsync_i;
  logic [23:0]      data_o;
  logic             vde_o;
  logic             hsync_o;
  logic             vsync_o;
  logic             seg_valid;
  logic [IDX_W-1:0] seg_idx;
  logic [23:0]      seg_rgb;
  logic             line_done;

  modport master (
    output data_i, vde_i, hsync_i, vsync_i,
    input  data_o, vde_o, hsync_o, vsync_o,
    input  seg_valid, seg_idx, seg_rgb, line_done
  );

  modport slave (
    input  data_i, vde_i, hsync_i, vsync_i,
    output data_o, vde_o, hsync_o, vsync_o,
    output seg_valid, seg_idx, seg_rgb, line_done
  );

endinterface

// File: rtl/scan_row_sampler_pos_cnt.sv
// Pixel position tracker: x/y counters, vsync edge detect, frame sync flag and row latch.
module vid_pos_cnt
  import scan_pkg::*;
#(
  parameter bit SYNC_POL = 1'b1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   vde_i,
  input  logic   vsync_i,
  input  coord_t scan_row,
  output coord_t x,
  output coord_t y,
  output coord_t row_lat,
  output logic   synced,
  output logic   vs_edge
);

  localparam coord_t COORD_MAX = '1;

  logic vde_d;
  logic vs_d;

  // vs_d resets to the active level so a genuine transition is required after reset.
  assign vs_edge = (vsync_i == SYNC_POL) && (vs_d != SYNC_POL);

  always_ff @(posedge clk) begin
    if (rst) begin
      x       <= '0;
      y       <= '0;
      row_lat <= '0;
      synced  <= 1'b0;
      vde_d   <= 1'b0;
      vs_d    <= SYNC_POL;
    end else begin
      vde_d <= vde_i;
      vs_d  <= vsync_i;

      if (!vde_i)
        x <= '0;
      else if (x != COORD_MAX)
        x <= x + coord_t'(1);

      if (vs_edge) begin
        y       <= '0;
        synced  <= 1'b1;
        row_lat <= scan_row;
      end else if (vde_d && !vde_i && (y != COORD_MAX)) begin
        y <= y + coord_t'(1);
      end
    end
  end

endmodule

// File: rtl/scan_row_sampler.sv
// Forwards video with one cycle of delay and averages colour over fixed-width segments
// of a selectable scan row, emitting one RGB value per segment.
module scan_row_sampler
  import scan_pkg::*;
#(
  parameter int          SEG_X0     = 64,
  parameter int          SEG_W_LOG2 = 3,
  parameter int          NUM_SEGS   = 32,
  parameter bit          SYNC_POL   = 1'b1,
  parameter logic [23:0] MARK_RGB   = 24'hFF00FF
) (
  input  logic              clk,
  input  logic              rst,
  input  coord_t            scan_row,
  input  logic              mark_en,
  scan_row_sampler_if.slave vid
);

  localparam int                 IDX_W    = $clog2(NUM_SEGS);
  localparam int                 ACC_W    = 8 + SEG_W_LOG2;
  localparam logic [COORD_W:0]   X_LO     = (COORD_W+1)'(SEG_X0);
  localparam logic [COORD_W:0]   X_HI     = (COORD_W+1)'(SEG_X0 + (NUM_SEGS << SEG_W_LOG2));
  localparam coord_t             SEG_MASK = coord_t'((1 << SEG_W_LOG2) - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SEGS - 1);

  coord_t x;
  coord_t y;
  coord_t row_lat;
  logic   synced;
  logic   vs_edge;

  vid_pos_cnt #(
    .SYNC_POL (SYNC_POL)
  ) u_pos (
    .clk      (clk),
    .rst      (rst),
    .vde_i    (vid.vde_i),
    .vsync_i  (vid.vsync_i),
    .scan_row (scan_row),
    .x        (x),
    .y        (y),
    .row_lat  (row_lat),
    .synced   (synced),
    .vs_edge  (vs_edge)
  );

  // ---- stage p0: window decode and running sums on the current pixel ----
  rgb_t             pix_p0;
  rgb_t             avg_p0;
  coord_t           off_p0;
  logic [IDX_W-1:0] seg_num_p0;
  logic             in_span_p0;
  logic             on_row_p0;
  logic             in_win_p0;
  logic             ovl_p0;
  logic             seg_last_p0;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_g;
  logic [ACC_W-1:0] acc_b;
  logic [ACC_W-1:0] sum_r_p0;
  logic [ACC_W-1:0] sum_g_p0;
  logic [ACC_W-1:0] sum_b_p0;

  assign pix_p0      = vid.data_i;
  assign in_span_p0  = ({1'b0, x} >= X_LO) && ({1'b0, x} < X_HI);
  assign on_row_p0   = synced && vid.vde_i && (y == row_lat);
  assign ovl_p0      = mark_en && on_row_p0 && in_span_p0;
  // A vsync edge mid-segment discards whatever has been gathered so far.
  assign in_win_p0   = on_row_p0 && in_span_p0 && !vs_edge;
  assign off_p0      = x - X_LO[COORD_W-1:0];
  assign seg_num_p0  = IDX_W'(off_p0 >> SEG_W_LOG2);
  assign seg_last_p0 = (off_p0 & SEG_MASK) == SEG_MASK;

  assign sum_r_p0 = acc_r + ACC_W'(pix_p0.r);
  assign sum_g_p0 = acc_g + ACC_W'(pix_p0.g);
  assign sum_b_p0 = acc_b + ACC_W'(pix_p0.b);

  always_comb begin
    avg_p0.r = rgb_avg(SUM_W'(sum_r_p0), SEG_W_LOG2);
    avg_p0.g = rgb_avg(SUM_W'(sum_g_p0), SEG_W_LOG2);
    avg_p0.b = rgb_avg(SUM_W'(sum_b_p0), SEG_W_LOG2);
  end

  // ---- stage p1: registered outputs and accumulator update ----
  logic [23:0]      data_p1;
  logic             vde_p1;
  logic             hsync_p1;
  logic             vsync_p1;
  logic             vld_p1;
  logic [IDX_W-1:0] idx_p1;
  rgb_t             rgb_p1;
  logic             done_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1  <= '0;
      vde_p1   <= 1'b0;
      hsync_p1 <= 1'b0;
      vsync_p1 <= 1'b0;
      vld_p1   <= 1'b0;
      idx_p1   <= '0;
      rgb_p1   <= '0;
      done_p1  <= 1'b0;
      acc_r    <= '0;
      acc_g    <= '0;
      acc_b    <= '0;
    end else begin
      data_p1  <= ovl_p0 ? MARK_RGB : vid.data_i;
      vde_p1   <= vid.vde_i;
      hsync_p1 <= vid.hsync_i;
      vsync_p1 <= vid.vsync_i;
      vld_p1   <= 1'b0;
      done_p1  <= vld_p1 && (idx_p1 == LAST_IDX);

      if (in_win_p0 && seg_last_p0) begin
        vld_p1 <= 1'b1;
        idx_p1 <= seg_num_p0;
        rgb_p1 <= avg_p0;
        acc_r  <= '0;
        acc_g  <= '0;
        acc_b  <= '0;
      end else if (in_win_p0) begin
        acc_r <= sum_r_p0;
        acc_g <= sum_g_p0;
        acc_b <= sum_b_p0;
      end else begin
        acc_r <= '0;
        acc_g <= '0;
        acc_b <= '0;
      end
    end
  end

  assign vid.data_o    = data_p1;
  assign vid.vde_o     = vde_p1;
  assign vid.hsync_o   = hsync_p1;
  assign vid.vsync_o   = vsync_p1;
  assign vid.seg_valid = vld_p1;
  assign vid.seg_idx   = idx_p1;
  assign vid.seg_rgb   = rgb_p1;
  assign vid.line_done = done_p1;

endmodule

// File: tb/tb_scan_row_sampler.sv
// Scoreboard bench for scan_row_sampler: frame-level reference model feeds expectation queues.
module tb_scan_row_sampler;
  import scan_pkg::*;

  localparam int          SEG_X0     = 16;
  localparam int          SEG_W_LOG2 = 2;
  localparam int          NUM_SEGS   = 4;
  localparam int          IDX_W      = 2;
  localparam int          SEG_W      = 1 << SEG_W_LOG2;
  localparam int          X_END      = SEG_X0 + NUM_SEGS * SEG_W;
  localparam logic [23:0] MARK       = 24'hFF00FF;

  logic   clk = 1'b0;
  logic   rst;
  coord_t scan_row;
  logic   mark_en;

  scan_row_sampler_if #(.IDX_W(IDX_W)) vid ();

  scan_row_sampler #(
    .SEG_X0     (SEG_X0),
    .SEG_W_LOG2 (SEG_W_LOG2),
    .NUM_SEGS   (NUM_SEGS),
    .SYNC_POL   (1'b1),
    .MARK_RGB   (MARK)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_row (scan_row),
    .mark_en  (mark_en),
    .vid      (vid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] data;
    logic        de;
    logic        hs;
    logic        vs;
    logic        rst;
  } pt_t;

  typedef struct {
    int          idx;
    logic [23:0] rgb;
    int          due;
  } seg_t;

  pt_t  exp_pt[$];
  seg_t exp_seg[$];
  pt_t  mon_p;
  seg_t mon_s;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  bit   m_synced = 1'b0;
  int   m_lat    = 0;
  bit   ld_due   = 1'b0;
  bit   seg_due;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: pass-through every cycle, segment results whenever due or presented.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (exp_pt.size() > 0) begin
      mon_p = exp_pt.pop_front();
      check("passthru", {5'd0, vid.data_o, vid.vde_o, vid.hsync_o, vid.vsync_o},
            {5'd0, mon_p.data, mon_p.de, mon_p.hs, mon_p.vs});
      if (mon_p.rst)
        check("reset_outputs", {4'd0, vid.seg_valid, vid.seg_idx, vid.seg_rgb, vid.line_done}, 32'd0);
    end
    if (ld_due || vid.line_done)
      check("line_done", {31'd0, vid.line_done}, {31'd0, ld_due});
    seg_due = (exp_seg.size() > 0) && (exp_seg[0].due == cyc);
    ld_due  = 1'b0;
    if (seg_due || vid.seg_valid)
      check("seg_valid", {31'd0, vid.seg_valid}, {31'd0, seg_due});
    if (seg_due) begin
      mon_s = exp_seg.pop_front();
      check("seg_idx", {30'd0, vid.seg_idx}, mon_s.idx);
      check("seg_rgb", {8'd0, vid.seg_rgb}, {8'd0, mon_s.rgb});
      ld_due = (mon_s.idx == NUM_SEGS - 1);
    end
  end

  task automatic drive(input logic [23:0] d, input logic de, input logic hs, input logic vs,
                       input logic r, input logic ovl);
    pt_t p;
    @(negedge clk);
    rst         = r;
    vid.data_i  = d;
    vid.vde_i   = de;
    vid.hsync_i = hs;
    vid.vsync_i = vs;
    p.data = r ? 24'd0 : (ovl ? MARK : d);
    p.de   = r ? 1'b0 : de;
    p.hs   = r ? 1'b0 : hs;
    p.vs   = r ? 1'b0 : vs;
    p.rst  = r;
    exp_pt.push_back(p);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) drive(24'($urandom), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic vsync_pulse();
    m_synced = 1'b1;
    m_lat    = int'(scan_row);
    for (int i = 0; i < 3; i++) drive(24'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    blank(3);
  endtask

  // mode 0: random pixels, 1: every channel = x, 2: constant 0x102030
  task automatic line(input int row, input int npix, input int mode, input int rst_at);
    logic [23:0] px[];
    px = new[npix];
    for (int i = 0; i < npix; i++)
      px[i] = (mode == 1) ? {3{8'(i)}} : (mode == 2) ? 24'h102030 : 24'($urandom);
    for (int i = 0; i < 2; i++) drive(24'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    blank($urandom_range(4, 1));
    for (int i = 0; i < npix; i++) begin
      bit r;
      bit hit;
      r = (rst_at >= 0) && (i >= rst_at) && (i < rst_at + 2);
      if (r) m_synced = 1'b0;
      hit = m_synced && (row == m_lat) && (i >= SEG_X0) && (i < X_END);
      drive(px[i], 1'b1, 1'b0, 1'b0, r, hit && mark_en);
      if (hit && ((i - SEG_X0) % SEG_W == SEG_W - 1)) begin
        seg_t s;
        s.idx = (i - SEG_X0) / SEG_W;
        for (int c = 0; c < 3; c++) begin
          int sum;
          sum = 0;
          for (int k = i - SEG_W + 1; k <= i; k++) sum += int'((px[k] >> (8 * c)) & 24'hFF);
          s.rgb[8*c +: 8] = 8'(sum / SEG_W);
        end
        s.due = cyc + 1;
        exp_seg.push_back(s);
      end
    end
    blank($urandom_range(5, 2));
  endtask

  task automatic frame(input int nlines, input int sp_row, input int sp_npix, input int sp_mode,
                       input int sp_rst);
    vsync_pulse();
    for (int r = 0; r < nlines; r++) begin
      if (r == sp_row) line(r, sp_npix, sp_mode, sp_rst);
      else             line(r, 100, 0, -1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst         = 1'b1;
    scan_row    = '0;
    mark_en     = 1'b0;
    vid.data_i  = '0;
    vid.vde_i   = 1'b0;
    vid.hsync_i = 1'b0;
    vid.vsync_i = 1'b0;
    for (int i = 0; i < 3; i++) drive(24'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // no vsync since reset: nothing may be sampled
    for (int r = 0; r < 3; r++) line(r, 100, 2, -1);

    scan_row = 12'd2;
    frame(6, 2, 100, 1, -1);
    frame(6, 2, 22, 0, -1);

    // scan_row change mid-frame takes effect only at the next vsync
    vsync_pulse();
    for (int r = 0; r < 7; r++) begin
      if (r == 2) scan_row = 12'd5;
      line(r, 100, 0, -1);
    end
    frame(7, -1, 100, 0, -1);

    mark_en  = 1'b1;
    scan_row = 12'd3;
    frame(5, -1, 100, 0, -1);
    mark_en  = 1'b0;

    // reset during segment 2 of the scan row
    scan_row = 12'd2;
    frame(4, 2, 100, 0, 26);
    line(4, 100, 0, -1);
    line(5, 100, 0, -1);
    frame(4, -1, 100, 0, -1);

    // latched row beyond the frame height
    scan_row = 12'd9;
    frame(5, -1, 100, 0, -1);

    for (int f = 0; f < 4; f++) begin
      scan_row = 12'($urandom_range(5, 0));
      mark_en  = 1'($urandom_range(1, 0));
      vsync_pulse();
      for (int r = 0; r < 6; r++) line(r, $urandom_range(100, 10), 0, -1);
    end
    mark_en = 1'b0;
    blank(5);
    @(negedge clk);
    @(negedge clk);

    check("seg_queue_empty", exp_seg.size(), 32'd0);
    check("pt_queue_empty", exp_pt.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
